// File: rtl/bram_arbiter_2p18x8b.sv
// Round-robin arbiter and command sequencer sharing one single-port frame BRAM
// between the image loader (port 0) and the median-filter window fetcher (port 1).
module bram_arbiter_2p18x8b #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clka,
    input  logic                  rst,
    // Port 0 request / response
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    // Port 1 request / response
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    // BRAM port A
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [DATA_WIDTH-1:0] bram_dina,
    input  logic [DATA_WIDTH-1:0] bram_douta,
    output logic                  busy
);

    // Handshake: a request is accepted on the rising edge where reqN_valid and
    // reqN_ready are both high; the requester holds we/addr/wdata stable until then.
    // Responses are never back-pressured: rspN_valid is a single-cycle pulse.

    logic                  last_q, last_d;    // id of the last granted port
    logic                  grant0, grant1;
    logic                  accept;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;

    logic                  ena_q, ena_d;
    logic                  wea_q, wea_d;
    logic [ADDR_WIDTH-1:0] addra_q, addra_d;
    logic [DATA_WIDTH-1:0] dina_q, dina_d;

    // Stage 0 travels alongside the command register; stage RD_LATENCY lines up
    // with valid douta.
    logic [RD_LATENCY:0]   tag_vld_q, tag_vld_d;
    logic [RD_LATENCY:0]   tag_id_q, tag_id_d;

    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        accept    = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = req0_addr;
        acc_wdata = req0_wdata;
        last_d    = last_q;

        if (!rst) begin
            grant0 = req0_valid && (!req1_valid || last_q);
            grant1 = req1_valid && !grant0;
        end
        accept = grant0 || grant1;

        if (grant1) begin
            acc_we    = req1_we;
            acc_addr  = req1_addr;
            acc_wdata = req1_wdata;
        end else if (grant0) begin
            acc_we    = req0_we;
            acc_addr  = req0_addr;
            acc_wdata = req0_wdata;
        end

        if (accept) begin
            last_d = grant1;
        end
    end

    always_comb begin
        ena_d     = accept;
        wea_d     = accept && acc_we;
        addra_d   = accept ? acc_addr : addra_q;
        dina_d    = accept ? acc_wdata : dina_q;
        tag_vld_d = {tag_vld_q[RD_LATENCY-1:0], accept && !acc_we};
        tag_id_d  = {tag_id_q[RD_LATENCY-1:0], grant1};
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            last_q    <= 1'b1;   // port 0 wins the first contended cycle
            ena_q     <= 1'b0;
            wea_q     <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            last_q    <= last_d;
            ena_q     <= ena_d;
            wea_q     <= wea_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign rsp0_valid = tag_vld_q[RD_LATENCY] && !tag_id_q[RD_LATENCY];
    assign rsp1_valid = tag_vld_q[RD_LATENCY] && tag_id_q[RD_LATENCY];
    assign rsp0_data  = bram_douta;
    assign rsp1_data  = bram_douta;

    assign bram_ena   = ena_q;
    assign bram_wea   = wea_q;
    assign bram_addra = addra_q;
    assign bram_dina  = dina_q;

    assign busy = ena_q || (|tag_vld_q);

endmodule

// File: tb/tb_bram_arbiter_2p18x8b.sv
// Directed bench: three arbiter instances (RD_LATENCY 1, 2, 3) share the same
// request stimulus, each driving its own behavioural BRAM of matching latency.
module tb_bram_arbiter_2p18x8b;
  localparam int AW = 18;
  localparam int DW = 8;
  localparam int NI = 3;
  localparam int MAIN = 1;  // RD_LATENCY = 2 instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req0_valid, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic req1_valid, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;

  logic ready0 [NI];
  logic ready1 [NI];
  logic rsp0_v [NI];
  logic rsp1_v [NI];
  logic [DW-1:0] rsp0_d [NI];
  logic [DW-1:0] rsp1_d [NI];
  logic ena [NI];
  logic wea [NI];
  logic [AW-1:0] addra [NI];
  logic [DW-1:0] dina [NI];
  logic [DW-1:0] douta [NI];
  logic busy [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rpipe [LAT];

    bram_arbiter_2p18x8b #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) u_dut (
      .clka(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(ready0[g]), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_v[g]), .rsp0_data(rsp0_d[g]),
      .req1_valid(req1_valid), .req1_ready(ready1[g]), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_v[g]), .rsp1_data(rsp1_d[g]),
      .bram_ena(ena[g]), .bram_wea(wea[g]), .bram_addra(addra[g]),
      .bram_dina(dina[g]), .bram_douta(douta[g]), .busy(busy[g])
    );

    // BRAM: samples the command on the edge after the arbiter registers it;
    // read data appears LAT edges after (and including) that sampling edge.
    always @(posedge clk) begin
      if (ena[g] && wea[g]) mem[addra[g]] <= dina[g];
      if (ena[g] && !wea[g]) rpipe[0] <= mem[addra[g]];
      for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign douta[g] = rpipe[LAT-1];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  logic [DW-1:0] wv [3];

  initial begin
    wv[0] = 8'd123; wv[1] = 8'd45; wv[2] = 8'd67;

    // Reset held with both ports requesting
    rst = 1'b1;
    drive0(1'b1, 1'b0, 18'd5, 8'd0);
    drive1(1'b1, 1'b0, 18'd6, 8'd0);
    repeat (3) begin
      tick();
      chk("rst_ready0", 32'(ready0[MAIN]), 32'(1'b0));
      chk("rst_ready1", 32'(ready1[MAIN]), 32'(1'b0));
      chk("rst_ena", 32'(ena[MAIN]), 32'(1'b0));
      chk("rst_rsp0", 32'(rsp0_v[MAIN]), 32'(1'b0));
      chk("rst_rsp1", 32'(rsp1_v[MAIN]), 32'(1'b0));
      chk("rst_busy", 32'(busy[MAIN]), 32'(1'b0));
    end

    // Port 0 writes 123@0, 45@1, 67@2
    rst = 1'b0;
    drive1(1'b0, 1'b0, 18'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 1'b1, AW'(i), wv[i]);
      #1;
      chk("wr_ready0", 32'(ready0[MAIN]), 32'(1'b1));
      chk("wr_ready1", 32'(ready1[MAIN]), 32'(1'b0));
      tick();
      chk("wr_ena", 32'(ena[MAIN]), 32'(1'b1));
      chk("wr_wea", 32'(wea[MAIN]), 32'(1'b1));
      chk("wr_addra", 32'(addra[MAIN]), i);
      chk("wr_dina", 32'(dina[MAIN]), 32'(wv[i]));
      chk("wr_busy", 32'(busy[MAIN]), 32'(1'b1));
    end

    // Port 0 reads 0,1,2 back to back; response timing checked for every latency
    for (int m = 0; m < 7; m++) begin
      if (m < 3) begin
        drive0(1'b1, 1'b0, AW'(m), 8'd0);
        #1;
        chk($sformatf("rd_ready0_m%0d", m), 32'(ready0[MAIN]), 32'(1'b1));
      end else begin
        drive0(1'b0, 1'b0, 18'd0, 8'd0);
      end
      tick();
      if (m < 3) begin
        chk($sformatf("rd_wea_m%0d", m), 32'(wea[MAIN]), 32'(1'b0));
        chk($sformatf("rd_addra_m%0d", m), 32'(addra[MAIN]), m);
      end
      for (int g = 0; g < NI; g++) begin
        int lat;
        logic ev;
        lat = g + 1;
        ev = (m >= lat) && (m <= lat + 2);
        chk($sformatf("rd_rsp0_v_L%0d_m%0d", lat, m), 32'(rsp0_v[g]), 32'(ev));
        if (ev) chk($sformatf("rd_rsp0_d_L%0d_m%0d", lat, m), 32'(rsp0_d[g]), 32'(wv[m-lat]));
        chk($sformatf("rd_rsp1_v_L%0d_m%0d", lat, m), 32'(rsp1_v[g]), 32'(1'b0));
        if (m == 6) chk($sformatf("rd_idle_busy_L%0d", lat), 32'(busy[g]), 32'(1'b0));
      end
    end

    // Contention from reset: port 0 reads addr 0, port 1 reads addr 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive0(1'b1, 1'b0, 18'd0, 8'd0);
    drive1(1'b1, 1'b0, 18'd2, 8'd0);
    for (int m = 0; m < 9; m++) begin
      int k;
      logic e0, e1;
      if (m == 6) begin
        drive0(1'b0, 1'b0, 18'd0, 8'd0);
        drive1(1'b0, 1'b0, 18'd0, 8'd0);
      end
      if (m < 6) begin
        #1;
        chk($sformatf("ct_ready0_m%0d", m), 32'(ready0[MAIN]), 32'(m % 2 == 0));
        chk($sformatf("ct_ready1_m%0d", m), 32'(ready1[MAIN]), 32'(m % 2 == 1));
      end
      tick();
      if (m < 6) chk($sformatf("ct_addra_m%0d", m), 32'(addra[MAIN]), (m % 2 == 1) ? 2 : 0);
      k = m - 2;
      e0 = (k >= 0) && (k < 6) && (k % 2 == 0);
      e1 = (k >= 0) && (k < 6) && (k % 2 == 1);
      chk($sformatf("ct_rsp0_v_m%0d", m), 32'(rsp0_v[MAIN]), 32'(e0));
      if (e0) chk($sformatf("ct_rsp0_d_m%0d", m), 32'(rsp0_d[MAIN]), 32'(8'd123));
      chk($sformatf("ct_rsp1_v_m%0d", m), 32'(rsp1_v[MAIN]), 32'(e1));
      if (e1) chk($sformatf("ct_rsp1_d_m%0d", m), 32'(rsp1_d[MAIN]), 32'(8'd67));
    end

    // Write/read hazard: port 1 writes 200@1, port 0 reads addr 1 next cycle
    drive1(1'b1, 1'b1, 18'd1, 8'd200);
    #1;
    chk("hz_wr_ready1", 32'(ready1[MAIN]), 32'(1'b1));
    tick();
    drive1(1'b0, 1'b0, 18'd0, 8'd0);
    drive0(1'b1, 1'b0, 18'd1, 8'd0);
    #1;
    chk("hz_rd_ready0", 32'(ready0[MAIN]), 32'(1'b1));
    chk("hz_rd_ready1", 32'(ready1[MAIN]), 32'(1'b0));
    tick();
    drive0(1'b0, 1'b0, 18'd0, 8'd0);
    chk("hz_wea", 32'(wea[MAIN]), 32'(1'b0));
    chk("hz_addra", 32'(addra[MAIN]), 32'(18'd1));
    tick();
    chk("hz_rsp0_early", 32'(rsp0_v[MAIN]), 32'(1'b0));
    tick();
    chk("hz_rsp0_v", 32'(rsp0_v[MAIN]), 32'(1'b1));
    chk("hz_rsp0_d", 32'(rsp0_d[MAIN]), 32'(8'd200));
    chk("hz_rsp1_v", 32'(rsp1_v[MAIN]), 32'(1'b0));
    tick();

    // Reset mid-flight: port 1 read accepted, reset on the next edge
    drive1(1'b1, 1'b0, 18'd0, 8'd0);
    #1;
    chk("mf_ready1", 32'(ready1[MAIN]), 32'(1'b1));
    tick();
    chk("mf_busy_inflight", 32'(busy[MAIN]), 32'(1'b1));
    rst = 1'b1;
    #1;
    chk("mf_rst_ready0", 32'(ready0[MAIN]), 32'(1'b0));
    chk("mf_rst_ready1", 32'(ready1[MAIN]), 32'(1'b0));
    tick();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("mf_busy_L%0d", g + 1), 32'(busy[g]), 32'(1'b0));
      chk($sformatf("mf_ena_L%0d", g + 1), 32'(ena[g]), 32'(1'b0));
    end
    rst = 1'b0;
    drive1(1'b0, 1'b0, 18'd0, 8'd0);
    for (int m = 2; m < 5; m++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("mf_rsp1_L%0d_m%0d", g + 1, m), 32'(rsp1_v[g]), 32'(1'b0));
        chk($sformatf("mf_rsp0_L%0d_m%0d", g + 1, m), 32'(rsp0_v[g]), 32'(1'b0));
      end
    end
    drive0(1'b1, 1'b0, 18'd0, 8'd0);
    drive1(1'b1, 1'b0, 18'd2, 8'd0);
    #1;
    chk("mf_post_ready0", 32'(ready0[MAIN]), 32'(1'b1));
    chk("mf_post_ready1", 32'(ready1[MAIN]), 32'(1'b0));
    tick();

    // Port 0 was just granted; a reset must still restore port 0 priority
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("ptr_ready0", 32'(ready0[MAIN]), 32'(1'b1));
    chk("ptr_ready1", 32'(ready1[MAIN]), 32'(1'b0));
    tick();
    drive0(1'b0, 1'b0, 18'd0, 8'd0);
    drive1(1'b0, 1'b0, 18'd0, 8'd0);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
